alu_arith_arbiter: RTL and testbench

Shares one combinational 16-bit arithmetic ALU (add opcode 4'b0100, sub opcode 4'b0101) among NUM_REQ requesters.
- Each requester presents opcode and operands on a valid/ready handshake.
- A round-robin grant steers the chosen request onto the ALU; result and flags are captured in a single response register, tagged with the requester id.
- The block sits between decode/issue ports and the shared ALU instance in the core.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/alu_arith_arbiter.sv | 95 +++++++++
 tb/tb_alu_arith_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic ALU and the logic that feeds it.
// Opcode encodings, the data width and the response record all live here.
package alu_pkg;

    localparam int ALU_DATA_W = 16;

    localparam logic [3:0] ALU_OP_NOP = 4'b0000;
    localparam logic [3:0] ALU_OP_ADD = 4'b0100;
    localparam logic [3:0] ALU_OP_SUB = 4'b0101;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] data;
        logic                  carry;
        logic                  overflow;
        logic                  sign;
        logic                  illegal;
    } alu_rsp_t;

    function automatic logic is_arith_op(input logic [3:0] opcode);
        return (opcode == ALU_OP_ADD) || (opcode == ALU_OP_SUB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the pointer marks the highest-priority requester and
// moves one past each winner, so a waiting requester sees at most NUM_REQ-1 grants first.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic               clk,
    input  logic               rst_n,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic [ID_W-1:0] ptr;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            idx = sum[ID_W-1:0];
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (|grant) begin
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arith_arbiter.sv
// Shares one combinational add/sub ALU among NUM_REQ requesters and holds
// the result in a single response register tagged with the requester id.
module alu_arith_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int DATA_W  = ALU_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [4*NUM_REQ-1:0]      req_opcode,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [3:0]                alu_opcode,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_carry,
    input  logic                      alu_overflow,
    input  logic                      alu_sign,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_carry,
    output logic                      rsp_overflow,
    output logic                      rsp_sign,
    output logic                      rsp_illegal
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_valid;
    logic               can_accept;
    alu_rsp_t           rsp_q;

    // A draining response frees the register in the same cycle, hence rsp_ready reaches req_ready.
    assign can_accept  = !rsp_valid || rsp_ready;
    assign grant_valid = |grant;
    assign req_ready   = grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .enable    (can_accept),
        .clk       (clk),
        .rst_n     (rst_n),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        alu_opcode = ALU_OP_NOP;
        alu_a      = '0;
        alu_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_opcode = req_opcode[4*i +: 4];
                alu_a      = req_a[DATA_W*i +: DATA_W];
                alu_b      = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    // Illegal opcodes are still answered; the ALU returns zeros for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
        end else if (grant_valid) begin
            rsp_valid      <= 1'b1;
            rsp_id         <= grant_idx;
            rsp_q.data     <= alu_out;
            rsp_q.carry    <= alu_carry;
            rsp_q.overflow <= alu_overflow;
            rsp_q.sign     <= alu_sign;
            rsp_q.illegal  <= !is_arith_op(alu_opcode);
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    assign rsp_data     = rsp_q.data;
    assign rsp_carry    = rsp_q.carry;
    assign rsp_overflow = rsp_q.overflow;
    assign rsp_sign     = rsp_q.sign;
    assign rsp_illegal  = rsp_q.illegal;

endmodule

// File: tb/tb_alu_arith_arbiter.sv
// Directed bench for alu_arith_arbiter with a behavioural add/sub ALU attached.
module tb_alu_arith_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_opcode;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_out;
    logic        alu_carry;
    logic        alu_overflow;
    logic        alu_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_carry;
    logic        rsp_overflow;
    logic        rsp_sign;
    logic        rsp_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [22:0] rsp_vec;
    logic [22:0] exp_vec;
    logic [16:0] wide;

    assign rsp_vec = {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_overflow, rsp_sign, rsp_illegal};

    alu_arith_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_opcode   (req_opcode),
        .req_a        (req_a),
        .req_b        (req_b),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_out      (alu_out),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .alu_sign     (alu_sign),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_sign     (rsp_sign),
        .rsp_illegal  (rsp_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU: carry is carry-out on add and borrow on sub.
    always_comb begin
        wide         = '0;
        alu_out      = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_sign     = 1'b0;
        if (alu_opcode == 4'b0100) begin
            wide         = {1'b0, alu_a} + {1'b0, alu_b};
            alu_out      = wide[15:0];
            alu_carry    = wide[16];
            alu_overflow = (alu_a[15] == alu_b[15]) && (wide[15] != alu_a[15]);
            alu_sign     = wide[15];
        end else if (alu_opcode == 4'b0101) begin
            wide         = {1'b0, alu_a} - {1'b0, alu_b};
            alu_out      = wide[15:0];
            alu_carry    = wide[16];
            alu_overflow = (alu_a[15] != alu_b[15]) && (wide[15] != alu_a[15]);
            alu_sign     = wide[15];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic v);
        req_opcode[4*i +: 4] = op;
        req_a[16*i +: 16]    = a;
        req_b[16*i +: 16]    = b;
        req_valid[i]         = v;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        req_opcode = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b1;
        tick();
        tick();
        n_checks++;
        if (rsp_vec !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h expected %h", rsp_vec, 23'h0);
        end
        n_checks++;
        if (req_ready !== 4'b0000 || alu_opcode !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle: req_ready=%b alu_opcode=%b expected 0000/0000", req_ready, alu_opcode);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        set_req(0, 4'b0100, 16'h7FFF, 16'h0001, 1'b1);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001 || alu_a !== 16'h7FFF || alu_opcode !== 4'b0100) begin
            n_fail++;
            $display("FAIL add_grant: req_ready=%b alu_a=%h op=%b expected 0001/7fff/0100", req_ready, alu_a, alu_opcode);
        end
        tick();
        req_valid = '0;
        exp_vec = {1'b1, 2'd0, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0};
        n_checks++;
        if (rsp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL add_rsp: got %h expected %h", rsp_vec, exp_vec);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 16'h8000) begin
            n_fail++;
            $display("FAIL add_drain: valid=%b data=%h expected 0/8000", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_single_sub();
        set_req(2, 4'b0101, 16'h0000, 16'h0001, 1'b1);
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL sub_grant: req_ready=%b expected 0100", req_ready);
        end
        tick();
        req_valid = '0;
        exp_vec = {1'b1, 2'd2, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        n_checks++;
        if (rsp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL sub_rsp: got %h expected %h", rsp_vec, exp_vec);
        end
        tick();
    endtask

    // Pointer is at 3 here, so the rotation starts with requester 3.
    task automatic test_back_to_back();
        int exp_id;
        for (int i = 0; i < 4; i++) begin
            set_req(i, 4'b0100, 16'(i * 256), 16'h0001, 1'b1);
        end
        exp_id = 3;
        #1;
        for (int n = 0; n < 8; n++) begin
            n_checks++;
            if (req_ready !== 4'(1 << exp_id)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: req_ready=%b expected %b", n, req_ready, 4'(1 << exp_id));
            end
            tick();
            exp_vec = {1'b1, 2'(exp_id), 16'(exp_id * 256 + 1), 4'b0000};
            n_checks++;
            if (rsp_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got %h expected %h", n, rsp_vec, exp_vec);
            end
            exp_id = (exp_id + 1) % 4;
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        set_req(0, 4'b0101, 16'h0005, 16'h0003, 1'b1);
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        set_req(1, 4'b0100, 16'h0001, 16'hFFFF, 1'b1);
        set_req(3, 4'b0101, 16'h8000, 16'h0001, 1'b1);
        exp_vec = {1'b1, 2'd0, 16'h0002, 4'b0000};
        for (int n = 0; n < 3; n++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || rsp_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL bp_hold%0d: req_ready=%b rsp=%h expected 0000/%h", n, req_ready, rsp_vec, exp_vec);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_release: req_ready=%b expected 0010", req_ready);
        end
        tick();
        req_valid[1] = 1'b0;
        exp_vec = {1'b1, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0};
        #1;
        n_checks++;
        if (rsp_vec !== exp_vec || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL bp_req1: rsp=%h req_ready=%b expected %h/1000", rsp_vec, req_ready, exp_vec);
        end
        tick();
        req_valid[3] = 1'b0;
        exp_vec = {1'b1, 2'd3, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (rsp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL bp_req3: got %h expected %h", rsp_vec, exp_vec);
        end
        tick();
    endtask

    task automatic test_illegal();
        set_req(1, 4'b0000, 16'h1234, 16'h1111, 1'b1);
        #1;
        n_checks++;
        if (req_ready !== 4'b0010 || alu_opcode !== 4'b0000) begin
            n_fail++;
            $display("FAIL ill_grant: req_ready=%b op=%b expected 0010/0000", req_ready, alu_opcode);
        end
        tick();
        req_valid = '0;
        exp_vec = {1'b1, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        n_checks++;
        if (rsp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL ill_rsp: got %h expected %h", rsp_vec, exp_vec);
        end
        tick();
    endtask

    // Pointer is 2 after the illegal op; granting requester 1 leaves it at 2 again.
    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        set_req(1, 4'b0100, 16'h0010, 16'h0020, 1'b1);
        tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 16'h0030) begin
            n_fail++;
            $display("FAIL mid_pre: valid=%b id=%0d data=%h expected 1/1/0030", rsp_valid, rsp_id, rsp_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_vec !== 23'h0) begin
            n_fail++;
            $display("FAIL mid_async: got %h expected %h", rsp_vec, 23'h0);
        end
        for (int i = 0; i < 4; i++) begin
            set_req(i, 4'b0101, 16'(16'h0100 * (i + 1)), 16'h0001, 1'b1);
        end
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_first_grant: req_ready=%b expected 0001", req_ready);
        end
        tick();
        exp_vec = {1'b1, 2'd0, 16'h00FF, 4'b0000};
        n_checks++;
        if (rsp_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL mid_first_rsp: got %h expected %h", rsp_vec, exp_vec);
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_single_sub();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
